// File: rtl/fft32_pkg.sv
// Shared constants, FSM state type and bit-reversal helper for the 32-point FFT datapath.
package fft32_pkg;

  localparam int unsigned FFT_N     = 32;
  localparam int unsigned FFT_LOG2N = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev5(input logic [FFT_LOG2N-1:0] i);
    logic [FFT_LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < FFT_LOG2N; b++) begin
      r[b] = i[FFT_LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft32_word_mux.sv
// Combinational 32:1 word select over a flat frame bus.
module fft32_word_mux
  import fft32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [FFT_N*DATA_WIDTH-1:0] words,
  input  logic [FFT_LOG2N-1:0]        sel,
  output logic [DATA_WIDTH-1:0]       word_c
);

  always_comb begin
    word_c = '0;
    for (int k = 0; k < FFT_N; k++) begin
      if (sel == FFT_LOG2N'(k)) word_c = words[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/fft32_output_serializer.sv
// Captures a 32-word FFT frame in one cycle and streams it out over valid/ready.
// Define FFT32_BITREV_EN to emit bit-reversed storage in natural order.
module fft32_output_serializer
  import fft32_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic [FFT_N*DATA_WIDTH-1:0] in_bus,
  output logic                        busy,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic [FFT_LOG2N-1:0]        m_index,
  output logic                        m_last,
  output logic                        done,
  output logic                        overrun
);

  localparam logic [FFT_LOG2N-1:0] LAST_POS = FFT_LOG2N'(FFT_N - 1);

  state_t                      state;
  logic [FFT_LOG2N-1:0]        cnt;
  logic [FFT_N*DATA_WIDTH-1:0] frame_q;

  logic                        hs_c;
  logic                        final_c;
  logic                        load_ok_c;
  logic [FFT_LOG2N-1:0]        rd_pos_c;
  logic [FFT_LOG2N-1:0]        rd_addr_c;
  logic [DATA_WIDTH-1:0]       rd_word_c;

  assign hs_c      = (state == ST_STREAM) & m_ready;
  assign final_c   = hs_c & (cnt == LAST_POS);
  assign load_ok_c = load & ((state == ST_IDLE) | final_c);
  assign rd_pos_c  = cnt + FFT_LOG2N'(1);

`ifdef FFT32_BITREV_EN
  assign rd_addr_c = bitrev5(rd_pos_c);
`else
  assign rd_addr_c = rd_pos_c;
`endif

  // Pre-fetches the word for the next position so m_data is a register.
  fft32_word_mux #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_word_mux (
    .words  (frame_q),
    .sel    (rd_addr_c),
    .word_c (rd_word_c)
  );

  assign busy    = (state == ST_STREAM);
  assign m_valid = busy;
  assign m_index = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      frame_q <= '0;
      m_data  <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done <= final_c;
      if (load_ok_c) begin
        // Position 0 maps to element 0 in both orderings.
        frame_q <= in_bus;
        cnt     <= '0;
        state   <= ST_STREAM;
        m_data  <= in_bus[DATA_WIDTH-1:0];
        m_last  <= 1'b0;
        overrun <= 1'b0;
      end else begin
        if (load) overrun <= 1'b1;
        if (final_c) begin
          state  <= ST_IDLE;
          m_last <= 1'b0;
        end else if (hs_c) begin
          cnt    <= rd_pos_c;
          m_data <= rd_word_c;
          m_last <= (rd_pos_c == LAST_POS);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft32_output_serializer.sv
// Randomized self-checking bench for fft32_output_serializer against a frame-level model.
module tb_fft32_output_serializer;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load;
  logic [N*DW-1:0] in_bus;
  logic            busy;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [4:0]      m_index;
  logic            m_last;
  logic            done;
  logic            overrun;

  fft32_output_serializer #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .in_bus  (in_bus),
    .busy    (busy),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_index (m_index),
    .m_last  (m_last),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] nframe [N];
  logic [DW-1:0] mframe [N];
  logic [DW-1:0] got    [N];
  logic          e_valid;
  logic          e_done;
  logic          e_ovr;
  int            e_pos;
  int            hs_cnt;
  int            done_cnt;

  // Position -> element, computed arithmetically from the bit weights.
  function automatic int addr(input int i);
`ifdef FFT32_BITREV_EN
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) r = r * 2 + ((i >> b) % 2);
    return r;
`else
    return i;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_frame(input int base, input bit rnd);
    for (int k = 0; k < N; k++) begin
      nframe[k] = rnd ? DW'($urandom) : DW'(base + k);
      in_bus[k*DW +: DW] = nframe[k];
    end
  endtask

  task automatic model_reset();
    e_valid = 1'b0;
    e_done  = 1'b0;
    e_ovr   = 1'b0;
    e_pos   = 0;
    for (int k = 0; k < N; k++) mframe[k] = '0;
  endtask

  // One clock: drive, check at negedge, advance model, return at posedge+1.
  task automatic step(input logic ld, input logic rdy);
    bit hs, fin, acc;
    load    = ld;
    m_ready = rdy;
    @(negedge clk);
    check("valid", 32'(m_valid), 32'(e_valid));
    check("busy", 32'(busy), 32'(e_valid));
    check("done", 32'(done), 32'(e_done));
    check("overrun", 32'(overrun), 32'(e_ovr));
    if (e_valid) begin
      check("index", 32'(m_index), 32'(e_pos));
      check("data", 32'(m_data), 32'(mframe[addr(e_pos)]));
      check("last", 32'(m_last), 32'(e_pos == 31));
    end else begin
      check("last_idle", 32'(m_last), 32'(0));
    end
    if (done) done_cnt++;
    hs  = e_valid && rdy;
    fin = hs && (e_pos == 31);
    acc = ld && (!e_valid || fin);
    if (hs) begin
      got[m_index] = m_data;
      hs_cnt++;
    end
    e_done = fin;
    if (acc) begin
      for (int k = 0; k < N; k++) mframe[k] = nframe[k];
      e_pos   = 0;
      e_valid = 1'b1;
      e_ovr   = 1'b0;
    end else begin
      if (ld) e_ovr = 1'b1;
      if (fin) e_valid = 1'b0;
      else if (hs) e_pos++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_pos(input int pos);
    for (int c = 0; c < 200 && !(e_valid && e_pos == pos); c++) step(1'b0, 1'b1);
    check("reach_pos", 32'(e_valid && e_pos == pos), 32'(1));
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && e_valid; c++) step(1'b0, 1'b1);
    check("drained", 32'(e_valid), 32'(0));
    step(1'b0, 1'b1);
  endtask

  initial begin
    rst_n   = 1'b0;
    load    = 1'b1;
    m_ready = 1'b1;
    set_frame(100, 1'b0);
    model_reset();
    hs_cnt   = 0;
    done_cnt = 0;
    #1;
    check("rst_valid", 32'(m_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_last", 32'(m_last), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ovr", 32'(overrun), 32'(0));
    check("rst_index", 32'(m_index), 32'(0));
    check("rst_data", 32'(m_data), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_valid", 32'(m_valid), 32'(0));
    rst_n = 1'b1;

    // Basic frame and ordering.
    step(1'b0, 1'b1);
    hs_cnt = 0; done_cnt = 0;
    step(1'b1, 1'b1);
    drain();
    check("basic_hs", 32'(hs_cnt), 32'(32));
    check("basic_done", 32'(done_cnt), 32'(1));
    check("ord0", 32'(got[0]), 32'(100));
`ifdef FFT32_BITREV_EN
    check("ord1", 32'(got[1]), 32'(116));
    check("ord2", 32'(got[2]), 32'(108));
`else
    check("ord1", 32'(got[1]), 32'(101));
    check("ord2", 32'(got[2]), 32'(102));
`endif
    check("ord31", 32'(got[31]), 32'(131));

    // Backpressure at position 7.
    set_frame(0, 1'b1);
    hs_cnt = 0; done_cnt = 0;
    step(1'b1, 1'b1);
    run_to_pos(7);
    repeat (5) step(1'b0, 1'b0);
    drain();
    check("bp_hs", 32'(hs_cnt), 32'(32));
    check("bp_done", 32'(done_cnt), 32'(1));

    // Overrun at position 10, cleared by the next accepted load.
    set_frame(100, 1'b0);
    step(1'b1, 1'b1);
    run_to_pos(10);
    set_frame(200, 1'b0);
    step(1'b1, 1'b1);
    check("ovr_set", 32'(overrun), 32'(1));
    drain();
    check("ovr_sticky", 32'(overrun), 32'(1));
    set_frame(0, 1'b1);
    step(1'b1, 1'b1);
    check("ovr_clear", 32'(overrun), 32'(0));

    // Back-to-back frame loaded in the final-handshake cycle.
    run_to_pos(31);
    set_frame(0, 1'b1);
    hs_cnt = 0; done_cnt = 0;
    step(1'b1, 1'b1);
    check("b2b_valid", 32'(m_valid), 32'(1));
    check("b2b_index", 32'(m_index), 32'(0));
    check("b2b_data", 32'(m_data), 32'(nframe[0]));
    check("b2b_ovr", 32'(overrun), 32'(0));
    drain();
    check("b2b_hs", 32'(hs_cnt), 32'(33));
    check("b2b_done", 32'(done_cnt), 32'(2));

    // Random ready and sporadic loads.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) set_frame(0, 1'b1);
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0));
    end
    drain();

    // Reset mid-stream at position 20.
    set_frame(0, 1'b1);
    step(1'b1, 1'b1);
    run_to_pos(20);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(m_valid), 32'(0));
    check("mrst_busy", 32'(busy), 32'(0));
    check("mrst_done", 32'(done), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (5) step(1'b0, 1'b1);
    check("mrst_nodone", 32'(done_cnt), 32'(0));
    set_frame(0, 1'b1);
    hs_cnt = 0;
    step(1'b1, 1'b1);
    drain();
    check("mrst_after_hs", 32'(hs_cnt), 32'(32));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
